// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states,
// instruction width and the NOP returned on faults and idle cycles.
package imem_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one read port whose
// output register is loaded only on the read-enable edge. Contents are not reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rdata;

    // Both ports use non-blocking updates, so a read and a write to the same
    // word at one edge return the old contents.
    always_ff @(posedge clk) begin
        if (i_we && (32'(i_waddr) < 32'(DEPTH))) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/instr_mem_resp.sv
// Instruction fetch responder: accepts a fetch, waits WAIT_CYCLES, then
// presents a one-cycle response with the stored word or an access fault.
module instr_mem_resp
    import imem_pkg::*;
#(
    parameter  int DEPTH       = 1024,
    parameter  int WAIT_CYCLES = 2,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ins_mem_req_i,
    input  logic [31:0]   ins_address_i,
    output logic          ins_mem_ready_o,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_instr_o,
    output logic          rsp_err_o,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_data_i,
    output logic [1:0]    dbg_state_o
);
    // Handshake: a fetch is taken at a rising edge where ins_mem_req_i and
    // ins_mem_ready_o are both 1; otherwise the request is ignored.
    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic [3:0]         w_next_cnt;
    logic               r_err;
    logic               w_accept;
    logic               w_misaligned;
    logic               w_out_of_range;
    logic               w_rd_en;
    logic [INSTR_W-1:0] w_rdata;

    assign ins_mem_ready_o = (r_state != WAIT);
    assign w_accept        = ins_mem_req_i & ins_mem_ready_o;
    assign w_misaligned    = |ins_address_i[1:0];
    assign w_out_of_range  = ({2'b00, ins_address_i[31:2]} >= 32'(DEPTH));
    assign w_rd_en         = w_accept & ~w_misaligned & ~w_out_of_range;
    assign dbg_state_o     = r_state;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (load_we_i),
        .i_waddr (load_addr_i),
        .i_wdata (load_data_i),
        .i_re    (w_rd_en),
        .i_raddr (ins_address_i[AW+1:2]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_err <= w_misaligned | w_out_of_range;
            end
        end
    end

    // A zero wait count goes straight to RESP; otherwise the counter holds the
    // remaining WAIT cycles minus one and RESP follows the edge it reads zero.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = RESP;
                        w_next_cnt   = 4'd0;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = 4'(WAIT_CYCLES - 1);
                    end
                end else if (r_state == RESP) begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        rsp_valid_o = (r_state == RESP);
        rsp_err_o   = 1'b0;
        rsp_instr_o = NOP;
        if (rsp_valid_o) begin
            rsp_err_o   = r_err;
            rsp_instr_o = r_err ? NOP : w_rdata;
        end
    end
endmodule

// File: doc/instr_mem_resp.md
INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit instruction words stored.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 0..15: wait states between request acceptance and response.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ins_mem_req_i  input  1  fetch request from the fetch unit.
REQ-006 ins_address_i  input  32  byte address of the requested instruction.
REQ-007 ins_mem_ready_o  output  1  responder can accept a request this cycle.
REQ-008 rsp_valid_o  output  1  response valid, one-cycle pulse per accepted request.
REQ-009 rsp_instr_o  output  32  fetched instruction, qualified by rsp_valid_o.
REQ-010 rsp_err_o  output  1  access fault, qualified by rsp_valid_o.
REQ-011 load_we_i  input  1  program-load write enable.
REQ-012 load_addr_i  input  $clog2(DEPTH)  word index for the program-load write.
REQ-013 load_data_i  input  32  program-load write data.

Function
REQ-014 The block SHALL use FSM states IDLE, WAIT and RESP.
REQ-015 ins_mem_ready_o SHALL be 1 in IDLE and RESP, and 0 in WAIT.
REQ-016 A request SHALL be accepted at a rising edge where ins_mem_req_i=1 and ins_mem_ready_o=1; the address is captured at that edge.
REQ-017 On accept, the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-019 rsp_valid_o SHALL be 1 only in RESP; it SHALL first assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 In RESP without a new accept, the FSM SHALL return to IDLE. A new accept in RESP (back-to-back) SHALL follow REQ-017 instead.
REQ-021 The storage array SHALL be read at the accept edge into a data register. Load writes at or after that edge SHALL NOT affect the pending response (read-before-write).
REQ-022 If ins_address_i[1:0] != 0 at accept, the response SHALL be rsp_err_o=1 and rsp_instr_o=32'h0000_0013 (NOP).
REQ-023 If ins_address_i[31:2] >= DEPTH at accept, the response SHALL be rsp_err_o=1 and rsp_instr_o=NOP.
REQ-024 Otherwise the response SHALL be rsp_err_o=0 and rsp_instr_o=mem[ins_address_i[31:2]].
REQ-025 When rsp_valid_o=0, rsp_instr_o SHALL be NOP and rsp_err_o SHALL be 0.
REQ-026 A load write SHALL be accepted in any state and any cycle, and SHALL update mem[load_addr_i] at the edge where load_we_i=1.
REQ-027 ins_mem_req_i SHALL be ignored while ins_mem_ready_o=0; the requester must hold or re-issue the request.

Reset
REQ-028 Asserting reset SHALL immediately force: state IDLE, counter 0, rsp_valid_o=0, rsp_err_o=0, rsp_instr_o=NOP, and ins_mem_ready_o=1 while in IDLE.
REQ-029 Reset asserted mid-transaction SHALL drop the pending response with no rsp_valid_o pulse after release.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 A shared package imem_pkg SHALL hold the FSM state enum, the NOP constant, and the instruction width constant (32).
REQ-032 Storage SHALL be a sub-module imem_array: one synchronous write port and one read port registered on the read-enable edge.
REQ-033 Target implementation size: 120-400 lines of RTL.

Verification
REQ-034 Scenario 1: load mem[4]=32'hDEADBEEF; request address 0x10 with WAIT_CYCLES=2 -> rsp_valid_o=1 three cycles after accept, rsp_instr_o=DEADBEEF, rsp_err_o=0.
REQ-035 Scenario 2: request address 0x12 -> rsp_err_o=1, rsp_instr_o=0x00000013.
REQ-036 Scenario 3: with DEPTH=1024, request address 0x1000 -> rsp_err_o=1, rsp_instr_o=NOP.
REQ-037 Scenario 4: hold ins_mem_req_i=1 continuously -> accepts occur every WAIT_CYCLES+1 cycles; no accepts during WAIT.
REQ-038 Scenario 5: request word 4, then write mem[4]=0x1 in the next cycle -> response returns the old value.
REQ-039 Scenario 6: assert reset during WAIT -> no rsp_valid_o pulse; after release ins_mem_ready_o=1 and state is IDLE.
